sysid_boot_checker: RTL and testbench



---
 rtl/sysid_boot_checker.sv | 203 ++++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the ID and timestamp words from the SOPC sysid slave and checks them, with bounded retry.
// Optional periodic re-check is enabled by defining SYSID_CHECK_PERIODIC_EN.
module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1493023976,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned RETRY_MAX          = 3,
   parameter int unsigned RECHECK_PERIOD     = 1000000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [3:0]  retry_count
);

   if (READ_LATENCY > 3 || RETRY_MAX > 15 || RECHECK_PERIOD < 16) begin : g_param_check
      $error("sysid_boot_checker: parameter out of legal range");
   end

   localparam bit         ZERO_LAT = (READ_LATENCY == 0);
   localparam logic [1:0] LAT_LAST = ZERO_LAT ? 2'd0 : 2'(READ_LATENCY - 1);
   localparam logic [3:0] RMAX     = 4'(RETRY_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_WAIT_ID,
      S_RD_TS,
      S_WAIT_TS,
      S_CMP,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  wait_q, wait_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        idm_q, idm_d;
   logic        tsm_q, tsm_d;
   logic        pass_q, pass_d;
   logic        done_q, done_d;
   logic [3:0]  retry_q, retry_d;
   logic        restart;
`ifdef SYSID_CHECK_PERIODIC_EN
   localparam logic [31:0] PERIOD = 32'(RECHECK_PERIOD);
   logic [31:0] period_q, period_d;
`endif

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      id_d          = id_q;
      ts_d          = ts_q;
      idm_d         = idm_q;
      tsm_d         = tsm_q;
      pass_d        = pass_q;
      done_d        = done_q;
      retry_d       = retry_q;
      restart       = 1'b0;
      sysid_read    = 1'b0;
      sysid_address = 1'b0;
`ifdef SYSID_CHECK_PERIODIC_EN
      period_d      = period_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD_ID;
               restart = 1'b1;
            end
         end
         S_RD_ID: begin
            sysid_read = 1'b1;
            if (ZERO_LAT) begin
               id_d    = sysid_readdata;
               state_d = S_RD_TS;
            end else begin
               wait_d  = '0;
               state_d = S_WAIT_ID;
            end
         end
         S_WAIT_ID: begin
            if (wait_q == LAT_LAST) begin
               id_d    = sysid_readdata;
               state_d = S_RD_TS;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         S_RD_TS: begin
            sysid_read    = 1'b1;
            sysid_address = 1'b1;
            if (ZERO_LAT) begin
               ts_d    = sysid_readdata;
               state_d = S_CMP;
            end else begin
               wait_d  = '0;
               state_d = S_WAIT_TS;
            end
         end
         S_WAIT_TS: begin
            sysid_address = 1'b1;
            if (wait_q == LAT_LAST) begin
               ts_d    = sysid_readdata;
               state_d = S_CMP;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         S_CMP: begin
            idm_d = (id_q != EXPECTED_ID);
            tsm_d = (ts_q != EXPECTED_TIMESTAMP);
`ifdef SYSID_CHECK_PERIODIC_EN
            period_d = PERIOD;
`endif
            if (id_q == EXPECTED_ID && ts_q == EXPECTED_TIMESTAMP) begin
               pass_d  = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (retry_q < RMAX) begin
               retry_d = retry_q + 4'd1;
               state_d = S_RD_ID;
            end else begin
               pass_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               state_d = S_RD_ID;
               restart = 1'b1;
`ifdef SYSID_CHECK_PERIODIC_EN
            end else if (period_q == '0) begin
               // internal re-check keeps done/pass/flags so pass cannot glitch low
               state_d = S_RD_ID;
               retry_d = '0;
            end else begin
               period_d = period_q - 32'd1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (restart) begin
         done_d  = 1'b0;
         pass_d  = 1'b0;
         idm_d   = 1'b0;
         tsm_d   = 1'b0;
         retry_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         wait_q   <= '0;
         id_q     <= '0;
         ts_q     <= '0;
         idm_q    <= 1'b0;
         tsm_q    <= 1'b0;
         pass_q   <= 1'b0;
         done_q   <= 1'b0;
         retry_q  <= '0;
`ifdef SYSID_CHECK_PERIODIC_EN
         period_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         id_q     <= id_d;
         ts_q     <= ts_d;
         idm_q    <= idm_d;
         tsm_q    <= tsm_d;
         pass_q   <= pass_d;
         done_q   <= done_d;
         retry_q  <= retry_d;
`ifdef SYSID_CHECK_PERIODIC_EN
         period_q <= period_d;
`endif
      end
   end

   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_mismatch = idm_q;
   assign ts_mismatch = tsm_q;
   assign id_value    = id_q;
   assign ts_value    = ts_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomized self-checking bench: two checkers (read latency 0 and 2) against a behavioural sysid slave and outcome model.
module tb_sysid_boot_checker;

   localparam logic [31:0] EXP_ID   = 32'd0;
   localparam logic [31:0] EXP_TS   = 32'd1493023976;
   localparam int          RMAX     = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        start_s = '0;
   logic [1:0]        addr_s, rd_s, busy_s, done_s, pass_s, idm_s, tsm_s;
   logic [1:0][31:0]  rdata_s, idv_s, tsv_s;
   logic [1:0][3:0]   retry_s;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                nrd [2];
   int                base [2];
   logic [31:0]       id_w [2][16];
   logic [31:0]       ts_w [2][16];
   logic              p_v [2];
   logic [31:0]       p_w [2];
   logic [31:0]       garbage;

   always #5 clk = ~clk;

   sysid_boot_checker #(.READ_LATENCY(0), .RETRY_MAX(RMAX)) u_dut0 (
      .clock(clk), .reset_n(rst_n), .start(start_s[0]),
      .sysid_address(addr_s[0]), .sysid_read(rd_s[0]), .sysid_readdata(rdata_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
      .id_mismatch(idm_s[0]), .ts_mismatch(tsm_s[0]),
      .id_value(idv_s[0]), .ts_value(tsv_s[0]), .retry_count(retry_s[0]));

   sysid_boot_checker #(.READ_LATENCY(2), .RETRY_MAX(RMAX)) u_dut1 (
      .clock(clk), .reset_n(rst_n), .start(start_s[1]),
      .sysid_address(addr_s[1]), .sysid_read(rd_s[1]), .sysid_readdata(rdata_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
      .id_mismatch(idm_s[1]), .ts_mismatch(tsm_s[1]),
      .id_value(idv_s[1]), .ts_value(tsv_s[1]), .retry_count(retry_s[1]));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   // Slave word for the current read: pass index is (reads so far in this check)/2.
   function automatic logic [31:0] slave_word(input int d, input logic a);
      int k = (nrd[d] - base[d]) / 2;
      if (k < 0) k = 0;
      if (k > 15) k = 15;
      return a ? ts_w[d][k] : id_w[d][k];
   endfunction

   always_comb begin
      rdata_s[0] = rd_s[0] ? slave_word(0, addr_s[0]) : garbage;
      rdata_s[1] = p_v[1] ? p_w[1] : garbage;
   end

   // Latency-2 slave pipeline and read counters
   logic        q0_v;
   logic [31:0] q0_w;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nrd[0] <= 0; nrd[1] <= 0;
         q0_v <= 1'b0; q0_w <= '0;
         p_v[0] <= 1'b0; p_w[0] <= '0;
         p_v[1] <= 1'b0; p_w[1] <= '0;
         garbage <= 32'hDEAD_BEEF;
      end else begin
         if (rd_s[0]) nrd[0] <= nrd[0] + 1;
         if (rd_s[1]) nrd[1] <= nrd[1] + 1;
         q0_v    <= rd_s[1];
         q0_w    <= slave_word(1, addr_s[1]);
         p_v[1]  <= q0_v;
         p_w[1]  <= q0_w;
         garbage <= $urandom;
      end
   end

   // Protocol monitor: reads alternate ID/TS and only occur while busy
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_n && rd_s[d]) begin
            check_eq("rd_addr_order", {31'd0, addr_s[d]}, 32'((nrd[d] - base[d]) % 2));
            check_eq("rd_while_busy", {31'd0, busy_s[d]}, 32'd1);
         end
      end
   end

   task automatic check_all_zero(input int d);
      check_eq("rst_busy",  {31'd0, busy_s[d]}, 32'd0);
      check_eq("rst_done",  {31'd0, done_s[d]}, 32'd0);
      check_eq("rst_pass",  {31'd0, pass_s[d]}, 32'd0);
      check_eq("rst_idm",   {31'd0, idm_s[d]},  32'd0);
      check_eq("rst_tsm",   {31'd0, tsm_s[d]},  32'd0);
      check_eq("rst_read",  {31'd0, rd_s[d]},   32'd0);
      check_eq("rst_addr",  {31'd0, addr_s[d]}, 32'd0);
      check_eq("rst_idv",   idv_s[d], 32'd0);
      check_eq("rst_tsv",   tsv_s[d], 32'd0);
      check_eq("rst_retry", {28'd0, retry_s[d]}, 32'd0);
   endtask

   // kind: 0 random words, 1 all good, 2 timestamp always off by one, 3 ID=5 on first pass only
   task automatic fill_words(input int d, input int kind);
      for (int p = 0; p < 16; p++) begin
         id_w[d][p] = EXP_ID;
         ts_w[d][p] = EXP_TS;
         case (kind)
            0: begin
               if ($urandom_range(0, 2) == 0) id_w[d][p] = $urandom;
               if ($urandom_range(0, 2) == 0) ts_w[d][p] = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
            end
            2: ts_w[d][p] = 32'd1493023977;
            3: if (p == 0) id_w[d][p] = 32'd5;
            default: ;
         endcase
      end
   endtask

   task automatic run_check(input int d, input int kind, input bit poke);
      int lat, p, cyc;
      bit ok;
      lat = (d == 0) ? 0 : 2;
      fill_words(d, kind);
      ok = 0;
      p = 0;
      while (!ok && p <= RMAX) begin
         ok = (id_w[d][p] == EXP_ID) && (ts_w[d][p] == EXP_TS);
         if (!ok) p++;
      end
      if (!ok) p = RMAX;
      @(negedge clk);
      base[d] = nrd[d];
      start_s[d] = 1'b1;
      @(negedge clk);
      start_s[d] = 1'b0;
      cyc = 1;
      check_eq("busy_cycle1", {31'd0, busy_s[d]}, 32'd1);
      check_eq("done_cleared", {31'd0, done_s[d]}, 32'd0);
      while (!done_s[d] && cyc < 300) begin
         start_s[d] = poke && (cyc == 2 || cyc == 3);
         @(negedge clk);
         cyc++;
      end
      start_s[d] = 1'b0;
      check_eq("done_cycle", cyc, 32'(4 + 2 * lat + p * (3 + 2 * lat)));
      check_eq("pass", {31'd0, pass_s[d]}, {31'd0, ok});
      check_eq("retry_count", {28'd0, retry_s[d]}, 32'(p));
      check_eq("id_mismatch", {31'd0, idm_s[d]}, {31'd0, id_w[d][p] != EXP_ID});
      check_eq("ts_mismatch", {31'd0, tsm_s[d]}, {31'd0, ts_w[d][p] != EXP_TS});
      check_eq("id_value", idv_s[d], id_w[d][p]);
      check_eq("ts_value", tsv_s[d], ts_w[d][p]);
      check_eq("busy_at_done", {31'd0, busy_s[d]}, 32'd0);
      repeat (3) @(negedge clk);
      check_eq("read_count", 32'(nrd[d] - base[d]), 32'(2 * (p + 1)));
      check_eq("done_held", {31'd0, done_s[d]}, 32'd1);
      check_eq("pass_held", {31'd0, pass_s[d]}, {31'd0, ok});
   endtask

   initial begin
      base[0] = 0; base[1] = 0;
      fill_words(0, 1);
      fill_words(1, 1);
      #1;
      check_all_zero(0);
      check_all_zero(1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_check(0, 1, 0);
      run_check(1, 1, 0);
      run_check(0, 2, 0);
      run_check(1, 2, 0);
      run_check(0, 3, 0);
      run_check(1, 3, 1);

      // Reset during WAIT_TS of the latency-2 checker
      fill_words(1, 1);
      @(negedge clk);
      base[1] = nrd[1];
      start_s[1] = 1'b1;
      @(negedge clk);
      start_s[1] = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero(1);
      check_all_zero(0);
      @(negedge clk);
      rst_n = 1'b1;
      run_check(1, 1, 0);
      run_check(0, 1, 1);

      for (int t = 0; t < 30; t++)
         run_check(t % 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
